// File: rtl/fetch_sequencer_if.sv
// ROM read port and decode-side valid/ready handshake of the fetch sequencer.
// master = sequencer side, slave = ROM/decode side.
interface fetch_sequencer_if;
    logic [15:0] rom_addr_out;
    logic [8:0]  rom_instr_in;
    logic [8:0]  instr_out;
    logic [15:0] instr_pc_out;
    logic        instr_valid_out;
    logic        instr_ready_in;

    modport master (
        output rom_addr_out,
        input  rom_instr_in,
        output instr_out,
        output instr_pc_out,
        output instr_valid_out,
        input  instr_ready_in
    );

    modport slave (
        input  rom_addr_out,
        output rom_instr_in,
        input  instr_out,
        input  instr_pc_out,
        input  instr_valid_out,
        output instr_ready_in
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Front end: owns the PC, reads the ROM, queues words toward decode, handles redirects and HALT.
// Optional FETCH_PERF_EN adds saturating fetch/flush counters.
module fetch_sequencer #(
    parameter int          QDEPTH     = 2,
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter logic [8:0]  HALT_WORD  = 9'h1FF
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        start_in,
    fetch_sequencer_if.master bus,
    input  logic        br_ctrl,
    input  logic        accdata_in,
    input  logic        jmp_ctrl,
    input  logic [7:0]  dst_in,
    output logic        halt_out,
    output logic        busy_out
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   pc_q, pc_d;
    logic [15:0]   last_pc_q;
    logic [8:0]    word_q [QDEPTH];
    logic [15:0]   wpc_q  [QDEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] cnt_q;

    logic        valid;
    logic        pop;
    logic        full;
    logic        redir;
    logic        take_start;
    logic        push;
    logic        halt_push;
    logic        drain_done;
    logic [15:0] target;

    assign valid = cnt_q != '0;
    assign pop   = valid & bus.instr_ready_in;
    assign full  = cnt_q == CW'(QDEPTH);
    assign redir = (state_q != IDLE) & (jmp_ctrl | (br_ctrl & accdata_in));

    // Branch offsets are relative to the last word decode accepted.
    assign target = jmp_ctrl ? {8'h00, dst_in}
                             : last_pc_q + {{8{dst_in[7]}}, dst_in};

    assign take_start = start_in & ~redir
                      & ((state_q == IDLE) | (state_q == HALT));
    assign push       = (state_q == RUN) & ~redir & (~full | pop);
    assign halt_push  = push & (bus.rom_instr_in == HALT_WORD);
    assign drain_done = (state_q == DRAIN) & ~redir
                      & pop & (cnt_q == CW'(1));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            redir:      state_d = RUN;
            take_start: state_d = RUN;
            halt_push:  state_d = DRAIN;
            drain_done: state_d = HALT;
            default:    ;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            redir:      pc_d = target;
            take_start: pc_d = START_ADDR;
            push:       pc_d = pc_q + 16'd1;
            default:    ;
        endcase
    end

    always_comb begin
        bus.rom_addr_out    = pc_q;
        bus.instr_valid_out = valid;
        bus.instr_out       = valid ? word_q[head_q] : '0;
        bus.instr_pc_out    = valid ? wpc_q[head_q] : '0;
        halt_out            = state_q == HALT;
        busy_out            = (state_q == RUN) | (state_q == DRAIN);
    end

    // A pop in the redirect cycle still records its PC.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            last_pc_q <= '0;
        end else begin
            if (pop) begin
                last_pc_q <= wpc_q[head_q];
            end
            if (redir) begin
                head_q <= '0;
                tail_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (pop) begin
                    head_q <= head_q + PW'(1);
                end
                if (push) begin
                    tail_q <= tail_q + PW'(1);
                end
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                word_q[i] <= '0;
                wpc_q[i]  <= '0;
            end
        end else if (push) begin
            word_q[tail_q] <= bus.rom_instr_in;
            wpc_q[tail_q]  <= pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (take_start) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push && fetch_cnt_q != 16'hFFFF) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (redir && valid && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: queue-based reference model plus
// directed phases (linear, backpressure, branch, jump, halt, wrap, async reset).
module tb_fetch_sequencer;
    localparam int          QD    = 2;
    localparam logic [15:0] START = 16'h0000;
    localparam logic [8:0]  HALTW = 9'h1FF;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;

    typedef struct {
        logic [8:0]  w;
        logic [15:0] pc;
    } ent_t;

    logic        CLK;
    logic        RST_n;
    logic        start;
    logic        start2;
    logic        br;
    logic        acc;
    logic        jmp;
    logic [7:0]  dst;
    logic        halt;
    logic        busy;
    logic        halt2;
    logic        busy2;
`ifdef FETCH_PERF_EN
    logic [15:0] pf_fetch, pf_flush, pf_fetch2, pf_flush2;
`endif

    logic [8:0] rom [65536];

    fetch_sequencer_if bus ();
    fetch_sequencer_if bus2 ();

    assign bus.rom_instr_in  = rom[bus.rom_addr_out];
    assign bus2.rom_instr_in = rom[bus2.rom_addr_out];
    assign bus2.instr_ready_in = 1'b1;

    fetch_sequencer #(
        .QDEPTH(QD), .START_ADDR(START), .HALT_WORD(HALTW)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .start_in(start), .bus(bus),
        .br_ctrl(br), .accdata_in(acc), .jmp_ctrl(jmp), .dst_in(dst),
        .halt_out(halt), .busy_out(busy)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(pf_fetch), .perf_flush_cnt(pf_flush)
`endif
    );

    fetch_sequencer #(
        .QDEPTH(QD), .START_ADDR(16'hFFFE), .HALT_WORD(HALTW)
    ) dut2 (
        .CLK(CLK), .RST_n(RST_n), .start_in(start2), .bus(bus2),
        .br_ctrl(1'b0), .accdata_in(1'b0), .jmp_ctrl(1'b0), .dst_in(8'h00),
        .halt_out(halt2), .busy_out(busy2)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(pf_fetch2), .perf_flush_cnt(pf_flush2)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: front end as a list of queued words plus a PC.
    ent_t        mq[$];
    logic [15:0] mpc;
    logic [15:0] mlast;
    int          mst;
    int          mfetch;
    int          mflush;

    task automatic mreset();
        mq.delete();
        mpc    = 16'h0;
        mlast  = 16'h0;
        mst    = M_IDLE;
        mfetch = 0;
        mflush = 0;
    endtask

    task automatic mstep();
        bit          pop;
        bit          redir;
        logic [15:0] tgt;
        ent_t        e;
        pop   = (mq.size() > 0) && bus.instr_ready_in;
        redir = (mst != M_IDLE) && (jmp || (br && acc));
        tgt   = jmp ? {8'h00, dst} : mlast + {{8{dst[7]}}, dst};
        if (pop) mlast = mq[0].pc;
        if (redir) begin
            if (mq.size() > 0 && mflush < 65535) mflush++;
            mq.delete();
            mpc = tgt;
            mst = M_RUN;
        end else if (start && (mst == M_IDLE || mst == M_HALT)) begin
            mpc    = START;
            mst    = M_RUN;
            mfetch = 0;
            mflush = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (mst == M_RUN && mq.size() < QD) begin
                e.w  = rom[mpc];
                e.pc = mpc;
                mq.push_back(e);
                mpc = mpc + 16'd1;
                if (mfetch < 65535) mfetch++;
                if (e.w == HALTW) mst = M_DRAIN;
            end else if (mst == M_DRAIN && mq.size() == 0) begin
                mst = M_HALT;
            end
        end
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge CLK or negedge RST_n);
            if (!RST_n) mreset();
            else mstep();
        end
    end

    // Words accepted by decode, as seen on the DUT outputs.
    ent_t acc_log[$];

    initial begin
        ent_t e;
        forever begin
            @(negedge CLK);
            if (RST_n) begin
                chk("rom_addr", bus.rom_addr_out, mpc);
                chk("valid", bus.instr_valid_out, mq.size() > 0);
                if (mq.size() > 0) begin
                    chk("instr", bus.instr_out, mq[0].w);
                    chk("instr_pc", bus.instr_pc_out, mq[0].pc);
                end
                chk("halt", halt, mst == M_HALT);
                chk("busy", busy, mst == M_RUN || mst == M_DRAIN);
`ifdef FETCH_PERF_EN
                chk("perf_fetch", pf_fetch, mfetch);
                chk("perf_flush", pf_flush, mflush);
`endif
                if (bus.instr_valid_out && bus.instr_ready_in) begin
                    e.w  = bus.instr_out;
                    e.pc = bus.instr_pc_out;
                    acc_log.push_back(e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        cyc(1);
        RST_n = 1'b1;
    endtask

    task automatic chk_log(input string nm, input int idx,
                           input logic [15:0] pc, input logic [8:0] w);
        if (idx < acc_log.size()) begin
            chk({nm, "_pc"}, acc_log[idx].pc, pc);
            chk({nm, "_word"}, acc_log[idx].w, w);
        end else begin
            chk({nm, "_present"}, acc_log.size(), idx + 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        int idx;
        bit seq_ok;
        RST_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        br     = 1'b0;
        acc    = 1'b0;
        jmp    = 1'b0;
        dst    = 8'h00;
        bus.instr_ready_in = 1'b0;
        for (int i = 0; i < 65536; i++) rom[i] = 9'((i * 5 + 7) % 256);
        rom[0] = 9'h001;
        rom[1] = 9'h002;
        rom[2] = 9'h003;
        rom[3] = 9'h004;
        #1;
        chk("rst_addr", bus.rom_addr_out, 16'h0);
        chk("rst_valid", bus.instr_valid_out, 1'b0);
        chk("rst_instr", bus.instr_out, 9'h0);
        chk("rst_pc", bus.instr_pc_out, 16'h0);
        chk("rst_halt", halt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        cyc(2);
        RST_n = 1'b1;
        cyc(1);

        // Linear fetch
        bus.instr_ready_in = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("lin_valid_e0", bus.instr_valid_out, 1'b0);
        chk("lin_busy_e0", busy, 1'b1);
        cyc(1);
        chk("lin_valid_e1", bus.instr_valid_out, 1'b1);
        chk("lin_first", bus.instr_out, 9'h001);
        cyc(5);
        for (int i = 0; i < 4; i++)
            chk_log("lin", i, 16'(i), 9'(i + 1));

        // Backpressure
        do_reset();
        acc_log.delete();
        bus.instr_ready_in = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(5);
        chk("bp_valid", bus.instr_valid_out, 1'b1);
        chk("bp_addr", bus.rom_addr_out, 16'h0002);
        chk("bp_head", bus.instr_pc_out, 16'h0000);
        bus.instr_ready_in = 1'b1;
        cyc(6);
        chk("bp_count", acc_log.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("bp_order", acc_log[i].pc, 16'(i));

        // Taken branch: last accepted pc 5, offset -3
        bus.instr_ready_in = 1'b0;
        br  = 1'b1;
        acc = 1'b1;
        dst = 8'hFD;
        cyc(1);
        br  = 1'b0;
        acc = 1'b0;
        chk("br_flush", bus.instr_valid_out, 1'b0);
        bus.instr_ready_in = 1'b1;
        cyc(4);
        chk_log("br_tgt", 6, 16'h0002, 9'h003);

        // Branch not taken
        bus.instr_ready_in = 1'b0;
        br = 1'b1;
        cyc(1);
        br = 1'b0;
        chk("nt_valid", bus.instr_valid_out, 1'b1);
        bus.instr_ready_in = 1'b1;
        cyc(4);
        seq_ok = acc_log.size() > 9;
        for (int i = 7; i < acc_log.size(); i++)
            if (acc_log[i].pc != acc_log[i - 1].pc + 16'd1) seq_ok = 0;
        chk("nt_sequential", seq_ok, 1'b1);

        // Jump beats branch
        bus.instr_ready_in = 1'b0;
        idx = acc_log.size();
        jmp = 1'b1;
        br  = 1'b1;
        acc = 1'b1;
        dst = 8'h40;
        cyc(1);
        jmp = 1'b0;
        br  = 1'b0;
        acc = 1'b0;
        dst = 8'h00;
        bus.instr_ready_in = 1'b1;
        cyc(4);
        chk_log("jmp_tgt", idx, 16'h0040, 9'h047);

        // Halt
        rom[3] = HALTW;
        do_reset();
        acc_log.delete();
        bus.instr_ready_in = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(10);
        chk("halt_count", acc_log.size(), 4);
        chk_log("halt_w0", 0, 16'h0000, 9'h001);
        chk_log("halt_w3", 3, 16'h0003, 9'h1FF);
        chk("halt_out", halt, 1'b1);
        chk("halt_busy", busy, 1'b0);
        chk("halt_addr", bus.rom_addr_out, 16'h0004);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        chk_log("restart", 4, 16'h0000, 9'h001);
        chk("restart_halt", halt, 1'b0);
        cyc(6);

        // PC wrap on the second instance
        start2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        cyc(1);
        chk("wrap_pc0", bus2.instr_pc_out, 16'hFFFE);
        chk("wrap_w0", bus2.instr_out, 9'h0FD);
        cyc(1);
        chk("wrap_pc1", bus2.instr_pc_out, 16'hFFFF);
        cyc(1);
        chk("wrap_pc2", bus2.instr_pc_out, 16'h0000);
        chk("wrap_addr", bus2.rom_addr_out, 16'h0001);

        // Asynchronous reset mid-run
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        #1;
        chk("ar_pre_valid", bus.instr_valid_out, 1'b1);
        chk("ar_pre_addr", bus.rom_addr_out, 16'h0002);
        RST_n = 1'b0;
        #1;
        chk("ar_addr", bus.rom_addr_out, 16'h0);
        chk("ar_valid", bus.instr_valid_out, 1'b0);
        chk("ar_instr", bus.instr_out, 9'h0);
        chk("ar_pc", bus.instr_pc_out, 16'h0);
        chk("ar_halt", halt, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_busy2", busy2, 1'b0);
        @(posedge CLK);
        #2;
        RST_n = 1'b1;
        cyc(3);
        chk("ar_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
